// File: rtl/fpu_pkg.sv
// Shared FPU constants and types for the binary32 datapath units.
package fpu_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_W    = 8;
  localparam int          MANT_W   = 23;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [1:0]  OP_MUL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2
  } mul_state_t;

endpackage

// File: rtl/fpu_classify.sv
// Binary32 operand classifier: zero (incl. subnormal, flushed), infinity, NaN.
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  logic [EXP_W-1:0]  ex;
  logic [MANT_W-1:0] mx;

  assign ex = x[30:23];
  assign mx = x[22:0];

  // Subnormals report as zero; exponent all-ones splits on the mantissa.
  always_comb begin
    is_zero = (ex == '0);
    is_inf  = (ex == '1) && (mx == '0);
    is_nan  = (ex == '1) && (mx != '0);
  end

endmodule

// File: rtl/fpu_mul_iter.sv
// Iterative binary32 multiplier: 24-step shift-add mantissa engine,
// truncating rounding, fixed 26-cycle start-to-done latency.
module fpu_mul_iter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  mul_state_t        state, state_nx;
  logic [4:0]        cnt;
  logic [47:0]       p;
  logic [23:0]       ma, mb;
  logic signed [9:0] exp_sum;
  logic              sgn;
  logic              f_nan, f_inf, f_zero;

  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  fpu_classify u_cls_a (.x(a), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
  fpu_classify u_cls_b (.x(b), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

  logic accept, last_iter;
  assign accept    = (state == S_IDLE) && start;
  assign last_iter = (state == S_MUL) && (cnt == 5'd23);
  assign busy      = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state: start only looked at in IDLE, so starts while busy drop.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_MUL;
      S_MUL:   if (last_iter) state_nx = S_NORM;
      S_NORM:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Partial product for this iteration: ma shifted by the bit position of mb.
  logic [47:0] addend;
  assign addend = mb[cnt] ? ({24'b0, ma} << cnt) : 48'b0;

  // Normalise (product of two [1,2) mantissas lies in [1,4)) and pack.
  logic signed [9:0] exp_n;
  logic [22:0]       mant_n;
  logic [31:0]       res_nx;
  always_comb begin
    if (p[47]) begin
      mant_n = p[46:24];
      exp_n  = exp_sum + 10'sd1;
    end else begin
      mant_n = p[45:23];
      exp_n  = exp_sum;
    end
    if (f_nan)                res_nx = QNAN;
    else if (f_inf)           res_nx = {sgn, 8'hFF, 23'h0};
    else if (f_zero)          res_nx = {sgn, 31'h0};
    else if (exp_n >= 10'sd255) res_nx = {sgn, 8'hFF, 23'h0};
    else if (exp_n <= 10'sd0)   res_nx = {sgn, 31'h0};
    else                      res_nx = {sgn, exp_n[7:0], mant_n};
  end

  // Datapath: capture operands on accept, accumulate in MUL, publish in NORM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      p       <= '0;
      ma      <= '0;
      mb      <= '0;
      exp_sum <= '0;
      sgn     <= 1'b0;
      f_nan   <= 1'b0;
      f_inf   <= 1'b0;
      f_zero  <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt     <= '0;
        p       <= '0;
        ma      <= {1'b1, a[22:0]};
        mb      <= {1'b1, b[22:0]};
        exp_sum <= $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
        sgn     <= a[31] ^ b[31];
        f_nan   <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        f_inf   <= a_inf | b_inf;
        f_zero  <= a_zero | b_zero;
      end else if (state == S_MUL) begin
        p   <= p + addend;
        cnt <= cnt + 5'd1;
      end else if (state == S_NORM) begin
        result <= res_nx;
        done   <= 1'b1;
      end
    end
  end

endmodule
